// File: rtl/aes_output_buffer_pkg.sv
// Shared types and constants for the AES ciphertext output buffer.
package aes_output_buffer_pkg;

   localparam int unsigned AES_BLOCK_W = 128;

   typedef logic [AES_BLOCK_W-1:0] text_t;

   typedef enum logic {
      ST_IDLE,
      ST_STREAM
   } buf_state_e;

   function automatic int unsigned words_per_block(input int unsigned word_w);
      return AES_BLOCK_W / word_w;
   endfunction

endpackage

// File: rtl/aes_output_buffer_if.sv
// Word-stream handshake carrying ciphertext out of the buffer.
interface aes_output_buffer_if #(
   parameter int unsigned WORD_W = 32
);
   logic              out_valid;
   logic              out_ready;
   logic [WORD_W-1:0] out_data;
   logic              out_last;

   modport master (output out_valid, output out_data, output out_last, input out_ready);
   modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/aes_block_fifo.sv
// DEPTH-entry FIFO of 128-bit ciphertext blocks; full/empty derived from level.
module aes_block_fifo
   import aes_output_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  text_t                    din,
   output text_t                    dout,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

   text_t            mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == FULL_LVL);
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/aes_output_buffer.sv
// Buffers finished AES blocks and serialises them MSW-first onto a valid/ready word stream.
module aes_output_buffer
   import aes_output_buffer_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned WORD_W = 32
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     finished_encrypt,
   input  text_t                    final_text,
   aes_output_buffer_if.master      out_if,
   output logic                     buffer_full,
   output logic                     buffer_empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   input  logic                     clear_overflow
);
   localparam int unsigned N_WORDS = words_per_block(WORD_W);
   localparam int unsigned IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
   localparam int unsigned LVL_W   = $clog2(DEPTH) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

   buf_state_e       state;
   buf_state_e       state_nxt;
   logic [IDX_W-1:0] word_idx;
   logic             push;
   logic             pop;
   logic             xfer;
   logic             last_word;
   logic             out_valid;
   text_t            head;
   text_t            head_shifted;

   assign push      = finished_encrypt && !buffer_full;
   assign out_valid = (state == ST_STREAM);
   assign xfer      = out_valid && out_if.out_ready;
   assign last_word = (word_idx == LAST_IDX);
   assign pop       = xfer && last_word;

   aes_block_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .din     (final_text),
      .dout    (head),
      .level   (level),
      .full    (buffer_full),
      .empty   (buffer_empty)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         word_idx <= '0;
         overflow <= 1'b0;
      end else begin
         state <= state_nxt;
         if (xfer) word_idx <= last_word ? '0 : word_idx + 1'b1;
         // A drop at the same edge as a clear keeps the flag set.
         if (finished_encrypt && buffer_full) overflow <= 1'b1;
         else if (clear_overflow)             overflow <= 1'b0;
      end
   end

   // STREAM tracks level != 0 exactly, so out_valid comes straight from a register.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (push) state_nxt = ST_STREAM;
         ST_STREAM: if (pop && !push && (level == LVL_W'(1))) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      head_shifted     = head << (32'(word_idx) * WORD_W);
      out_if.out_valid = out_valid;
      out_if.out_last  = out_valid && last_word;
      out_if.out_data  = out_valid ? head_shifted[AES_BLOCK_W-1 -: WORD_W] : '0;
   end

endmodule

// File: tb/tb_aes_output_buffer.sv
// Directed bench for aes_output_buffer (DEPTH=4, WORD_W=32).
module tb_aes_output_buffer;
   import aes_output_buffer_pkg::*;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned WORD_W = 32;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       finished_encrypt = 1'b0;
   logic       clear_overflow = 1'b0;
   text_t      final_text = '0;
   logic       buffer_full;
   logic       buffer_empty;
   logic [2:0] level;
   logic       overflow;

   int n_checks = 0;
   int n_fail   = 0;

   aes_output_buffer_if #(.WORD_W(WORD_W)) out_if ();

   aes_output_buffer #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .finished_encrypt (finished_encrypt),
      .final_text       (final_text),
      .out_if           (out_if),
      .buffer_full      (buffer_full),
      .buffer_empty     (buffer_empty),
      .level            (level),
      .overflow         (overflow),
      .clear_overflow   (clear_overflow)
   );

   always #5 clk = ~clk;

   text_t blocks [8] = '{
      128'h10111213_14151617_18191A1B_1C1D1E1F,
      128'h20212223_24252627_28292A2B_2C2D2E2F,
      128'h30313233_34353637_38393A3B_3C3D3E3F,
      128'h40414243_44454647_48494A4B_4C4D4E4F,
      128'h50515253_54555657_58595A5B_5C5D5E5F,
      128'h60616263_64656667_68696A6B_6C6D6E6F,
      128'h70717273_74757677_78797A7B_7C7D7E7F,
      128'h80818283_84858687_88898A8B_8C8D8E8F
   };

   function automatic logic [31:0] word_of(input text_t b, input int unsigned w);
      logic [31:0] words [4];
      words[0] = b[127:96];
      words[1] = b[95:64];
      words[2] = b[63:32];
      words[3] = b[31:0];
      return words[w];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      out_if.out_ready = 1'b0;
      #12;
      n_checks++; if (out_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", out_if.out_valid); end
      n_checks++; if (out_if.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %0b want 0", out_if.out_last); end
      n_checks++; if (out_if.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_if.out_data); end
      n_checks++; if (buffer_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %0b want 1", buffer_empty); end
      n_checks++; if (buffer_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b want 0", buffer_full); end
      n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      tick();
      n_checks++; if (out_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid: got %0b want 0", out_if.out_valid); end
   endtask

   task automatic test_single_block();
      logic [31:0] exp [4] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
      out_if.out_ready = 1'b1;
      finished_encrypt = 1'b1;
      final_text = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      tick();
      finished_encrypt = 1'b0;
      final_text = '0;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (out_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid[%0d]: got %0b want 1", i, out_if.out_valid); end
         n_checks++; if (out_if.out_data !== exp[i]) begin n_fail++; $display("FAIL single_data[%0d]: got %h want %h", i, out_if.out_data, exp[i]); end
         n_checks++; if (out_if.out_last !== (i == 3)) begin n_fail++; $display("FAIL single_last[%0d]: got %0b want %0b", i, out_if.out_last, (i == 3)); end
         n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL single_level[%0d]: got %0d want 1", i, level); end
         tick();
      end
      n_checks++; if (out_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_done_valid: got %0b want 0", out_if.out_valid); end
      n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL single_done_level: got %0d want 0", level); end
      n_checks++; if (buffer_empty !== 1'b1) begin n_fail++; $display("FAIL single_done_empty: got %0b want 1", buffer_empty); end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp [4] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
      logic        pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      int unsigned k = 0;
      out_if.out_ready = 1'b0;
      finished_encrypt = 1'b1;
      final_text = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      tick();
      finished_encrypt = 1'b0;
      for (int c = 0; c < 7; c++) begin
         out_if.out_ready = pat[c];
         n_checks++; if (out_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %0b want 1", c, out_if.out_valid); end
         n_checks++; if (out_if.out_data !== exp[k]) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", c, out_if.out_data, exp[k]); end
         n_checks++; if (out_if.out_last !== (k == 3)) begin n_fail++; $display("FAIL bp_last[%0d]: got %0b want %0b", c, out_if.out_last, (k == 3)); end
         tick();
         if (pat[c]) k++;
      end
      out_if.out_ready = 1'b0;
      n_checks++; if (out_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_done_valid: got %0b want 0", out_if.out_valid); end
      n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL bp_done_level: got %0d want 0", level); end
   endtask

   task automatic test_fill_overflow();
      out_if.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         finished_encrypt = 1'b1;
         final_text = blocks[i];
         tick();
         if (i < 4) begin
            n_checks++; if (level !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, level, i + 1); end
            n_checks++; if (buffer_full !== (i == 3)) begin n_fail++; $display("FAIL fill_full[%0d]: got %0b want %0b", i, buffer_full, (i == 3)); end
            n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_overflow[%0d]: got %0b want 0", i, overflow); end
         end else begin
            n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL drop_overflow: got %0b want 1", overflow); end
            n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL drop_level: got %0d want 4", level); end
         end
      end
      finished_encrypt = 1'b0;
      final_text = '0;
      out_if.out_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         n_checks++; if (out_if.out_data !== word_of(blocks[k / 4], k % 4)) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", k, out_if.out_data, word_of(blocks[k / 4], k % 4)); end
         n_checks++; if (out_if.out_last !== ((k % 4) == 3)) begin n_fail++; $display("FAIL drain_last[%0d]: got %0b want %0b", k, out_if.out_last, ((k % 4) == 3)); end
         tick();
      end
      out_if.out_ready = 1'b0;
      n_checks++; if (buffer_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %0b want 1", buffer_empty); end
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL drain_overflow_sticky: got %0b want 1", overflow); end
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clear_overflow: got %0b want 0", overflow); end
   endtask

   task automatic test_full_pop_push();
      out_if.out_ready = 1'b0;
      for (int i = 4; i < 8; i++) begin
         finished_encrypt = 1'b1;
         final_text = blocks[i];
         tick();
      end
      finished_encrypt = 1'b0;
      n_checks++; if (buffer_full !== 1'b1) begin n_fail++; $display("FAIL fpp_full: got %0b want 1", buffer_full); end
      out_if.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) tick();
      n_checks++; if (out_if.out_last !== 1'b1) begin n_fail++; $display("FAIL fpp_last: got %0b want 1", out_if.out_last); end
      finished_encrypt = 1'b1;
      final_text = blocks[0];
      clear_overflow = 1'b1;
      tick();
      finished_encrypt = 1'b0;
      clear_overflow = 1'b0;
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fpp_overflow: got %0b want 1", overflow); end
      n_checks++; if (level !== 3'd3) begin n_fail++; $display("FAIL fpp_level: got %0d want 3", level); end
      n_checks++; if (buffer_full !== 1'b0) begin n_fail++; $display("FAIL fpp_full_after: got %0b want 0", buffer_full); end
      for (int k = 0; k < 12; k++) begin
         n_checks++; if (out_if.out_data !== word_of(blocks[5 + k / 4], k % 4)) begin n_fail++; $display("FAIL fpp_data[%0d]: got %h want %h", k, out_if.out_data, word_of(blocks[5 + k / 4], k % 4)); end
         tick();
      end
      out_if.out_ready = 1'b0;
      n_checks++; if (out_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_done_valid: got %0b want 0", out_if.out_valid); end
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
   endtask

   task automatic test_mid_reset();
      out_if.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         finished_encrypt = 1'b1;
         final_text = blocks[i];
         tick();
      end
      finished_encrypt = 1'b0;
      out_if.out_ready = 1'b1;
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++; if (out_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid: got %0b want 0", out_if.out_valid); end
      n_checks++; if (out_if.out_data !== 32'h0) begin n_fail++; $display("FAIL mrst_data: got %h want 0", out_if.out_data); end
      n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL mrst_level: got %0d want 0", level); end
      n_checks++; if (buffer_empty !== 1'b1) begin n_fail++; $display("FAIL mrst_empty: got %0b want 1", buffer_empty); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mrst_overflow: got %0b want 0", overflow); end
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         n_checks++; if (out_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_after_valid[%0d]: got %0b want 0", c, out_if.out_valid); end
      end
      out_if.out_ready = 1'b0;
   endtask

   task automatic test_concurrent_stream();
      int unsigned pushed = 0;
      int unsigned gap = 3;
      int unsigned rx = 0;
      int unsigned cycles = 0;
      while (rx < 32 && cycles < 600) begin
         if (pushed < 8 && gap >= 3 && !buffer_full) begin
            finished_encrypt = 1'b1;
            final_text = blocks[pushed];
            pushed++;
            gap = 1;
         end else begin
            finished_encrypt = 1'b0;
            gap++;
         end
         out_if.out_ready = ($urandom_range(0, 9) < 7);
         if (out_if.out_valid && out_if.out_ready) begin
            n_checks++; if (out_if.out_data !== word_of(blocks[rx / 4], rx % 4)) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", rx, out_if.out_data, word_of(blocks[rx / 4], rx % 4)); end
            n_checks++; if (out_if.out_last !== ((rx % 4) == 3)) begin n_fail++; $display("FAIL stream_last[%0d]: got %0b want %0b", rx, out_if.out_last, ((rx % 4) == 3)); end
            rx++;
         end
         tick();
         cycles++;
      end
      finished_encrypt = 1'b0;
      out_if.out_ready = 1'b0;
      n_checks++; if (rx != 32) begin n_fail++; $display("FAIL stream_count: got %0d words want 32 (cycle budget)", rx); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL stream_overflow: got %0b want 0", overflow); end
      n_checks++; if (buffer_empty !== 1'b1) begin n_fail++; $display("FAIL stream_empty: got %0b want 1", buffer_empty); end
   endtask

   initial begin
      out_if.out_ready = 1'b0;
      test_reset();
      test_single_block();
      test_backpressure();
      test_fill_overflow();
      test_full_pop_push();
      test_mid_reset();
      test_concurrent_stream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/aes_output_buffer.md
Name: aes_output_buffer

Overview:
- Downstream stage of the AES-128 core. Captures each finished ciphertext block (`final_text`, qualified by `finished_encrypt`) into a DEPTH-entry block FIFO.
- Streams stored blocks out as WORD_W-bit words over a valid/ready handshake, most significant word first.
- Reports `buffer_full` back to the core's start gating, so encryption is only launched when there is room for the result.

Parameters:
- DEPTH, 4: number of 128-bit ciphertext blocks stored. Power of two, at least 2.
- WORD_W, 32: output word width. Must be 8, 32, 64 or 128. Words per block is N_WORDS = 128/WORD_W.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  reset, asynchronous, active-low.
- finished_encrypt  input  1  ciphertext-valid pulse from the AES core.
- final_text  input  128 (text_t)  ciphertext block, sampled when finished_encrypt=1.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  WORD_W  current ciphertext word.
- out_last  output  1  current word is the final word of its block.
- buffer_full  output  1  level == DEPTH.
- buffer_empty  output  1  level == 0.
- level  output  $clog2(DEPTH)+1  number of stored blocks, including a partially sent one.
- overflow  output  1  sticky: a block was dropped.
- clear_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, level=0, word_idx=0, overflow=0. All outputs are then: out_valid=0, out_last=0, out_data=0, buffer_empty=1, buffer_full=0. Storage contents are don't-care.
- Reset mid-stream: any partially sent block is discarded; no further words are presented after release.
- Push:
  - Push occurs on a clk edge where finished_encrypt=1 and buffer_full=0.
  - Writes final_text to mem[wr_ptr]; wr_ptr increments modulo DEPTH.
  - finished_encrypt is level-qualified: every high cycle is a separate push.
- Push while full:
  - The block is dropped and overflow is set at that edge.
  - Push is rejected whenever the registered buffer_full=1, including the cycle in which a pop frees an entry. There is no same-cycle bypass.
- Output stream:
  - out_valid = !buffer_empty, from registered state only, so it has no combinational path from the inputs.
  - out_data = mem[rd_ptr][127 - word_idx*WORD_W -: WORD_W].
  - out_last = out_valid && (word_idx == N_WORDS-1).
  - When out_valid=0: out_data=0 and out_last=0.
- Latency: a block pushed at edge k presents word 0 from just after edge k, provided the buffer was empty.
- Transfer: occurs on an edge where out_valid=1 and out_ready=1.
  - If word_idx < N_WORDS-1: word_idx increments.
  - Else: word_idx=0, rd_ptr increments modulo DEPTH, level decrements (pop).
- Stability: while out_valid=1 and out_ready=0, out_data and out_last hold. A push never alters the word being presented.
- Simultaneous push and pop (buffer not full): level is unchanged and both pointers advance.
- Pointer wrap: pointers wrap at DEPTH; full/empty are derived from level, not from pointer compare.
- WORD_W=128: N_WORDS=1; word_idx is held at 0 and out_last = out_valid.
- Overflow clear:
  - clear_overflow=1 clears overflow at the next edge.
  - If a dropped push coincides with clear_overflow, set wins.
- Sequential state machine: two states.
  - IDLE (level==0) -> STREAM on push.
  - STREAM -> IDLE on a pop with level==1 and no simultaneous push.
  - STREAM -> STREAM otherwise.
  - This encoding is informational; the output equations above are normative.

Decomposition:
- DesignPkg owns:
  - text_t (existing).
  - New constant AES_BLOCK_W = 128.
  - New localparam-style function words_per_block(WORD_W).
- Sub-module aes_block_fifo (DEPTH x text_t): storage, wr_ptr/rd_ptr, level, full/empty, push/pop ports, async active-low reset.
- aes_output_buffer wraps it and adds the word serializer (word_idx, out_* logic) and overflow.

Test Plan:
- Reset check: assert reset_n=0 mid-stream -> out_valid=0, level=0, buffer_empty=1, overflow=0 immediately; after release with no push, out_valid stays 0.
- Single block, WORD_W=32, out_ready=1: push 128'h00112233_44556677_8899AABB_CCDDEEFF -> words 00112233, 44556677, 8899AABB, CCDDEEFF on 4 consecutive cycles, out_last only on CCDDEEFF; level goes 1 -> 0.
- Backpressure: same block, out_ready toggling 1,0,0,1,1,0,1 -> each word held stable while out_ready=0; exactly 4 transfers; order as above.
- Fill and overflow, DEPTH=4: push 5 blocks with out_ready=0 -> buffer_full=1 after the 4th; 5th dropped and overflow=1; drain -> 16 words from blocks 1-4 only. clear_overflow=1 -> overflow=0.
- Full plus pop-and-push same edge: at level=4, final word handshake coincident with push -> push rejected, overflow=1, level=3.
- Concurrent stream: push 8 distinct blocks, one every 3 cycles, with random out_ready at 70% -> scoreboard sees all 8 blocks in order with no overflow; pointers wrap once.
